pmem_arbiter: RTL and testbench
===============================

Name: pmem_arbiter

Overview:
- Shares the single physical-memory port between the I-cache (fetch-stage misses) and the D-cache (MEM-stage misses and writebacks) of the pipelined LC-3b core.
- One cache-line transaction is in flight at a time.
- D-side has priority, bounded by an anti-starvation streak counter so fetch always progresses.
- Sits between the two cache miss controllers and the pmem interface in the cpu top level.

Parameters:
- LINE_W, 128, cache line width in bits.
- ADDR_W, 16, byte address width (lc3b_word).
- MAX_D_STREAK, 3, maximum consecutive D grants while I is waiting; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_pmem_read  in  1  I-cache line read request; held until i_pmem_resp
- i_pmem_address  in  ADDR_W  I-cache line address
- i_pmem_rdata  out  LINE_W  read data to I-cache
- i_pmem_resp  out  1  I transaction complete
- d_pmem_read  in  1  D-cache line read request
- d_pmem_write  in  1  D-cache line writeback request
- d_pmem_address  in  ADDR_W  D-cache line address
- d_pmem_wdata  in  LINE_W  D-cache writeback data
- d_pmem_rdata  out  LINE_W  read data to D-cache
- d_pmem_resp  out  1  D transaction complete
- pmem_read  out  1  physical memory read strobe
- pmem_write  out  1  physical memory write strobe
- pmem_address  out  ADDR_W  physical memory address
- pmem_wdata  out  LINE_W  physical memory write data
- pmem_rdata  in  LINE_W  physical memory read data
- pmem_resp  in  1  physical memory done

Behaviour:
- FSM states: IDLE, SERVE_I, SERVE_D. Reset state is IDLE.
- On reset, all of the following are 0: pmem_read, pmem_write, pmem_address, pmem_wdata, streak counter. i_pmem_resp and d_pmem_resp are 0.
- pmem_read, pmem_write, pmem_address and pmem_wdata are registers, loaded only on the grant edge and held constant through the transaction.
- IDLE grant decision, sampled at the rising edge:
  - D pending = d_pmem_read | d_pmem_write. I pending = i_pmem_read.
  - Only one side pending: grant it.
  - Both pending: grant D, unless streak == MAX_D_STREAK, in which case grant I.
  - Neither pending: stay in IDLE.
- Grant to D:
  - Latches d_pmem_address and d_pmem_wdata.
  - pmem_write = d_pmem_write; pmem_read = d_pmem_read & ~d_pmem_write. If both are asserted, the write wins.
  - Next state SERVE_D.
- Grant to I: latches i_pmem_address, pmem_read = 1, pmem_wdata unchanged, next state SERVE_I.
- Latency: a request seen in IDLE at edge N drives pmem strobes from the cycle after edge N. Minimum one dead cycle between the requester's assertion and the memory strobe.
- Streak counter (4 bits), updated on the grant edge:
  - D grant with I pending: +1, saturating at MAX_D_STREAK.
  - D grant with I not pending: cleared to 0.
  - I grant: cleared to 0.
- SERVE_x:
  - x_pmem_resp = pmem_resp, combinational, gated by state. The other side's resp is 0.
  - x_pmem_rdata = pmem_rdata in all states. Requesters qualify it with resp.
  - On the edge where pmem_resp = 1: clear pmem_read and pmem_write, go to IDLE.
- Mandatory IDLE cycle after every completion: requesters drop the request on the resp edge, so IDLE never re-grants a finished request.
- Requests, and changes to a requester's address or wdata, arriving during SERVE_x are ignored until IDLE.
- pmem_resp in IDLE is ignored. No resp is forwarded to either side.
- Reset mid-transaction: returns to IDLE immediately (asynchronous), strobes drop, the transaction is abandoned, and no resp is delivered.

Test Plan:
- I only: i_pmem_read = 1, addr 0x1230; memory responds 3 cycles after strobe with rdata 0xA5..A5. Required: pmem_read high 1 cycle after the request, pmem_address = 0x1230, i_pmem_resp pulses 1 cycle with i_pmem_rdata = 0xA5..A5, then back in IDLE; d_pmem_resp stays 0.
- D writeback: d_pmem_write = 1, addr 0x4000, wdata 0x1111..1111. Required: pmem_write = 1, pmem_read = 0, pmem_wdata held through the transaction, d_pmem_resp pulses once.
- Simultaneous first requests: I and D both requested in the same cycle. Required: D is served first, then I after one IDLE cycle; streak = 0 after the I grant.
- Starvation bound: MAX_D_STREAK = 2, D requests back-to-back continuously, I held high. Required: grant order D, D, I, D, D, I; the I latency is bounded.
- Conflicting D request: d_pmem_read = d_pmem_write = 1. Required: pmem_write = 1, pmem_read = 0.
- Reset mid-transaction: rst_n pulsed low during SERVE_I before pmem_resp. Required: pmem_read is 0 asynchronously, the state is IDLE, no i_pmem_resp is delivered, and a re-issued request is served normally.

Source files
------------

// File: rtl/pmem_arbiter.sv
// -----------------------------------------------------------------------------
// pmem_arbiter
//
// Shares the single physical-memory port between the I-cache miss controller
// and the D-cache miss/writeback controller. One cache-line transaction is in
// flight at a time. The D side wins ties, but a 4-bit streak counter bounds how
// many consecutive D grants may be issued while the I side is waiting, so
// instruction fetch always makes progress.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   i_pmem_read       I-cache line read request (held until i_pmem_resp)
//   i_pmem_address    I-cache line address
//   i_pmem_rdata      line read data to the I-cache (qualify with i_pmem_resp)
//   i_pmem_resp       I transaction complete
//   d_pmem_read       D-cache line read request
//   d_pmem_write      D-cache line writeback request
//   d_pmem_address    D-cache line address
//   d_pmem_wdata      D-cache writeback data
//   d_pmem_rdata      line read data to the D-cache (qualify with d_pmem_resp)
//   d_pmem_resp       D transaction complete
//   pmem_read/write   registered physical-memory strobes
//   pmem_address      registered physical-memory address
//   pmem_wdata        registered physical-memory write data
//   pmem_rdata        physical-memory read data
//   pmem_resp         physical-memory done
// -----------------------------------------------------------------------------
module pmem_arbiter #(
  parameter int unsigned LINE_W       = 128,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned MAX_D_STREAK = 3    // legal range 1..15
) (
  input  logic              clk,
  input  logic              rst_n,
  // I-cache side
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  // D-cache side
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  // physical memory side
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  localparam logic [3:0] MAX_STREAK = 4'(MAX_D_STREAK);

  state_e              state_q,   state_d;
  logic [3:0]          streak_q,  streak_d;
  logic                read_q,    read_d;
  logic                write_q,   write_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [LINE_W-1:0]   wdata_q,   wdata_d;

  logic d_pend;
  logic i_pend;
  logic take_d;

  assign d_pend = d_pmem_read | d_pmem_write;
  assign i_pend = i_pmem_read;
  // D wins a tie unless it has already used up its streak allowance.
  assign take_d = d_pend & (~i_pend | (streak_q != MAX_STREAK));

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    read_d    = read_q;
    write_d   = write_q;
    address_d = address_q;
    wdata_d   = wdata_q;

    case (state_q)
      IDLE: begin
        // pmem_resp is deliberately ignored here: nothing is outstanding.
        if (take_d) begin
          state_d   = SERVE_D;
          address_d = d_pmem_address;
          wdata_d   = d_pmem_wdata;
          write_d   = d_pmem_write;
          read_d    = d_pmem_read & ~d_pmem_write;  // writeback wins a conflict
          if (i_pend)
            streak_d = (streak_q == MAX_STREAK) ? streak_q : streak_q + 4'd1;
          else
            streak_d = 4'd0;
        end else if (i_pend) begin
          state_d   = SERVE_I;
          address_d = i_pmem_address;
          read_d    = 1'b1;
          write_d   = 1'b0;
          streak_d  = 4'd0;
        end
      end

      SERVE_I, SERVE_D: begin
        // Requester inputs are frozen out until the next IDLE; the strobes
        // only drop on completion, which forces one IDLE cycle in between.
        if (pmem_resp) begin
          state_d = IDLE;
          read_d  = 1'b0;
          write_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  // NOTE: all registers, including the wide address/data holding registers,
  // are cleared by the asynchronous reset so the pmem port is quiet and
  // deterministic the instant rst_n falls, abandoning any open transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      streak_q  <= 4'd0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      address_q <= '0;
      wdata_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q   <= state_d;
      streak_q  <= streak_d;
      read_q    <= read_d;
      write_q   <= write_d;
      address_q <= address_d;
      wdata_q   <= wdata_d;
    end
  end

  assign pmem_read    = read_q;
  assign pmem_write   = write_q;
  assign pmem_address = address_q;
  assign pmem_wdata   = wdata_q;

  // Completion is forwarded combinationally, only to the side being served.
  assign i_pmem_resp  = (state_q == SERVE_I) & pmem_resp;
  assign d_pmem_resp  = (state_q == SERVE_D) & pmem_resp;

  // Read data is broadcast; requesters qualify it with their resp.
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pmem_arbiter
//
// Directed, self-checking bench for pmem_arbiter, built with MAX_D_STREAK = 2.
// Inputs change and outputs are sampled 1 ns after the rising edge; the memory
// response is driven by hand in each step.
// -----------------------------------------------------------------------------
module tb_pmem_arbiter;

  localparam int unsigned LINE_W = 128;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned MAXS   = 2;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SERVE_I = 2'd1;
  localparam logic [1:0] S_SERVE_D = 2'd2;

  localparam logic [LINE_W-1:0] LINE_A5 = {16{8'hA5}};
  localparam logic [LINE_W-1:0] LINE_11 = {32{4'h1}};
  localparam logic [LINE_W-1:0] LINE_22 = {32{4'h2}};
  localparam logic [LINE_W-1:0] LINE_33 = {32{4'h3}};
  localparam logic [LINE_W-1:0] LINE_5C = {16{8'h5C}};

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pmem_arbiter #(
    .LINE_W       (LINE_W),
    .ADDR_W       (ADDR_W),
    .MAX_D_STREAK (MAXS)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                       input logic [LINE_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    i_pmem_read    = 1'b0;
    i_pmem_address = '0;
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    d_pmem_address = '0;
    d_pmem_wdata   = '0;
    pmem_rdata     = '0;
    pmem_resp      = 1'b0;

    // ---------------- reset state ----------------
    #2;
    check("rst_read",   pmem_read,    0);
    check("rst_write",  pmem_write,   0);
    check("rst_addr",   pmem_address, 0);
    check("rst_wdata",  pmem_wdata,   0);
    check("rst_streak", dut.streak_q, 0);
    check("rst_iresp",  i_pmem_resp,  0);
    check("rst_dresp",  d_pmem_resp,  0);
    step();
    rst_n = 1'b1;
    step();
    check("rst_state",  2'(dut.state_q), S_IDLE);

    // ---------------- I only ----------------
    i_pmem_read    = 1'b1;
    i_pmem_address = 16'h1230;
    #1;
    check("i_dead_cycle", pmem_read, 0);
    step();                                       // grant edge
    check("i_read",   pmem_read,    1);
    check("i_write",  pmem_write,   0);
    check("i_addr",   pmem_address, 16'h1230);
    check("i_wdata",  pmem_wdata,   0);
    check("i_state",  2'(dut.state_q), S_SERVE_I);
    step();
    step();
    check("i_hold_read", pmem_read, 1);
    check("i_no_early_resp", i_pmem_resp, 0);
    pmem_rdata = LINE_A5;
    pmem_resp  = 1'b1;
    #1;
    check("i_resp",   i_pmem_resp,  1);
    check("i_rdata",  i_pmem_rdata, LINE_A5);
    check("i_dresp0", d_pmem_resp,  0);
    step();                                       // completion edge
    i_pmem_read = 1'b0;
    pmem_resp   = 1'b0;
    #1;
    check("i_done_read",  pmem_read, 0);
    check("i_done_state", 2'(dut.state_q), S_IDLE);
    check("i_done_resp",  i_pmem_resp, 0);

    // ---------------- D writeback ----------------
    d_pmem_write   = 1'b1;
    d_pmem_address = 16'h4000;
    d_pmem_wdata   = LINE_11;
    step();
    check("dw_write", pmem_write,   1);
    check("dw_read",  pmem_read,    0);
    check("dw_addr",  pmem_address, 16'h4000);
    check("dw_wdata", pmem_wdata,   LINE_11);
    d_pmem_wdata   = LINE_22;                     // ignored while serving
    d_pmem_address = 16'h4440;
    step();
    check("dw_wdata_held", pmem_wdata,   LINE_11);
    check("dw_addr_held",  pmem_address, 16'h4000);
    pmem_resp = 1'b1;
    #1;
    check("dw_dresp", d_pmem_resp, 1);
    check("dw_iresp", i_pmem_resp, 0);
    step();
    d_pmem_write = 1'b0;
    pmem_resp    = 1'b0;
    #1;
    check("dw_done_write", pmem_write, 0);
    check("dw_done_state", 2'(dut.state_q), S_IDLE);
    check("dw_streak",     dut.streak_q, 0);

    // pmem_resp in IDLE is not forwarded
    pmem_resp = 1'b1;
    #1;
    check("idle_iresp", i_pmem_resp, 0);
    check("idle_dresp", d_pmem_resp, 0);
    step();
    pmem_resp = 1'b0;
    #1;
    check("idle_stays", 2'(dut.state_q), S_IDLE);

    // ---------------- simultaneous first requests ----------------
    i_pmem_read    = 1'b1;
    i_pmem_address = 16'h2000;
    d_pmem_read    = 1'b1;
    d_pmem_address = 16'h3000;
    step();
    check("sim_d_first", pmem_address, 16'h3000);
    check("sim_d_state", 2'(dut.state_q), S_SERVE_D);
    check("sim_streak1", dut.streak_q, 1);
    pmem_rdata = LINE_5C;
    pmem_resp  = 1'b1;
    #1;
    check("sim_dresp", d_pmem_resp, 1);
    check("sim_drdat", d_pmem_rdata, LINE_5C);
    step();
    d_pmem_read = 1'b0;
    pmem_resp   = 1'b0;
    #1;
    check("sim_idle_gap", 2'(dut.state_q), S_IDLE);
    step();
    check("sim_i_second", pmem_address, 16'h2000);
    check("sim_i_state",  2'(dut.state_q), S_SERVE_I);
    check("sim_streak0",  dut.streak_q, 0);
    pmem_resp = 1'b1;
    step();
    i_pmem_read = 1'b0;
    pmem_resp   = 1'b0;
    #1;

    // ---------------- starvation bound (MAX_D_STREAK = 2) ----------------
    i_pmem_read    = 1'b1;
    i_pmem_address = 16'h5000;
    d_pmem_read    = 1'b1;
    d_pmem_address = 16'h6000;
    for (int k = 0; k < 6; k++) begin
      logic is_i;
      is_i = (k % 3 == 2);                        // order D, D, I, D, D, I
      step();                                     // grant edge
      check($sformatf("stv_addr%0d", k), pmem_address,
            is_i ? 16'h5000 : 16'h6000);
      check($sformatf("stv_streak%0d", k), dut.streak_q,
            is_i ? 0 : (k % 3) + 1);
      pmem_resp = 1'b1;
      #1;
      check($sformatf("stv_iresp%0d", k), i_pmem_resp, is_i);
      check($sformatf("stv_dresp%0d", k), d_pmem_resp, !is_i);
      step();                                     // completion edge
      pmem_resp = 1'b0;
    end
    i_pmem_read = 1'b0;
    d_pmem_read = 1'b0;
    #1;

    // ---------------- conflicting D request ----------------
    d_pmem_read    = 1'b1;
    d_pmem_write   = 1'b1;
    d_pmem_address = 16'h7000;
    d_pmem_wdata   = LINE_33;
    step();
    check("cf_write", pmem_write, 1);
    check("cf_read",  pmem_read,  0);
    check("cf_wdata", pmem_wdata, LINE_33);
    pmem_resp = 1'b1;
    step();
    d_pmem_read  = 1'b0;
    d_pmem_write = 1'b0;
    pmem_resp    = 1'b0;
    #1;

    // ---------------- reset mid-transaction ----------------
    i_pmem_read    = 1'b1;
    i_pmem_address = 16'h8000;
    step();
    check("rm_read_before", pmem_read, 1);
    #2;
    rst_n     = 1'b0;
    pmem_resp = 1'b1;                             // must not reach I
    #1;
    check("rm_read_async", pmem_read, 0);
    check("rm_state",      2'(dut.state_q), S_IDLE);
    check("rm_no_iresp",   i_pmem_resp, 0);
    rst_n     = 1'b1;
    pmem_resp = 1'b0;
    step();                                       // request still held: re-grant
    check("rm_regrant_read", pmem_read, 1);
    check("rm_regrant_addr", pmem_address, 16'h8000);
    pmem_rdata = LINE_A5;
    pmem_resp  = 1'b1;
    #1;
    check("rm_iresp", i_pmem_resp, 1);
    step();
    i_pmem_read = 1'b0;
    pmem_resp   = 1'b0;
    #1;
    check("rm_done_state", 2'(dut.state_q), S_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
